// File: rtl/uart_serial_bridge.sv
// uart_serial_bridge: 8N1 UART <-> processor byte port.
// RX/TX FIFOs with sticky error flags, full duplex.

module uart_serial_bridge_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_rdata,
  output logic       o_empty,
  output logic       o_full,
  output logic       o_pop_ok
);

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic [7:0]  r_mem [DEPTH];
  logic        w_empty;
  logic        w_full;
  logic        w_do_pop;
  logic        w_do_push;

  // Status and accepted strobes; a full FIFO may push when it also pops
  always_comb begin
    w_empty   = (r_wptr == r_rptr);
    w_full    = (r_wptr[AW] != r_rptr[AW]) &&
                (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    w_do_pop  = i_pop && !w_empty;
    w_do_push = i_push && (!w_full || w_do_pop);
  end

  assign o_rdata  = r_mem[r_rptr[AW-1:0]];
  assign o_empty  = w_empty;
  assign o_full   = w_full;
  assign o_pop_ok = w_do_pop;

  // Storage and wrap-bit pointers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr[AW-1:0]] <= i_wdata;
        r_wptr <= r_wptr + (AW+1)'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + (AW+1)'(1);
      end
    end
  end

endmodule

module uart_serial_bridge #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic [7:0] rx_data_out,
  output logic       rx_valid_out,
  input  logic       rx_rden_in,
  output logic       tx_ready_out,
  input  logic [7:0] tx_data_in,
  input  logic       tx_wren_in,
  input  logic       err_clear_in,
  output logic       rx_overrun_out,
  output logic       rx_frame_err_out,
  output logic       tx_overflow_out
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  logic          r_rx_s1;
  logic          r_rx_s2;
  rx_state_t     r_rx_state;
  rx_state_t     w_rx_state_nx;
  logic [CW-1:0] r_rx_cnt;
  logic [CW-1:0] w_rx_cnt_nx;
  logic [2:0]    r_rx_bit;
  logic [2:0]    w_rx_bit_nx;
  logic [7:0]    r_rx_shift;
  logic [7:0]    w_rx_shift_nx;
  logic          w_rx_push;
  logic          w_rx_ferr_set;
  logic          w_rx_ovr_set;
  logic          w_rx_empty;
  logic          w_rx_full;
  logic          w_rx_pop_ok;

  tx_state_t     r_tx_state;
  tx_state_t     w_tx_state_nx;
  logic [CW-1:0] r_tx_cnt;
  logic [CW-1:0] w_tx_cnt_nx;
  logic [2:0]    r_tx_bit;
  logic [2:0]    w_tx_bit_nx;
  logic [7:0]    r_tx_shift;
  logic [7:0]    w_tx_shift_nx;
  logic          r_txd;
  logic          w_txd_nx;
  logic          w_tx_pop;
  logic          w_tx_pop_ok;
  logic          w_tx_empty;
  logic          w_tx_full;
  logic [7:0]    w_tx_head;
  logic          w_tx_ovf_set;

  logic          r_rx_overrun;
  logic          r_rx_frame_err;
  logic          r_tx_overflow;

  uart_serial_bridge_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_rx_fifo (
    .i_clk    (clock),
    .i_rst_n  (reset),
    .i_push   (w_rx_push),
    .i_pop    (rx_rden_in),
    .i_wdata  (r_rx_shift),
    .o_rdata  (rx_data_out),
    .o_empty  (w_rx_empty),
    .o_full   (w_rx_full),
    .o_pop_ok (w_rx_pop_ok)
  );

  uart_serial_bridge_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_tx_fifo (
    .i_clk    (clock),
    .i_rst_n  (reset),
    .i_push   (tx_wren_in),
    .i_pop    (w_tx_pop),
    .i_wdata  (tx_data_in),
    .o_rdata  (w_tx_head),
    .o_empty  (w_tx_empty),
    .o_full   (w_tx_full),
    .o_pop_ok (w_tx_pop_ok)
  );

  // Two-flop synchronizer, preset to the idle line level
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= uart_rxd;
      r_rx_s2 <= r_rx_s1;
    end
  end

  // RX state and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_state <= w_rx_state_nx;
      r_rx_cnt   <= w_rx_cnt_nx;
      r_rx_bit   <= w_rx_bit_nx;
      r_rx_shift <= w_rx_shift_nx;
    end
  end

  // RX next state: mid-bit sampling, push or flag on the stop bit
  always_comb begin
    w_rx_state_nx = r_rx_state;
    w_rx_cnt_nx   = r_rx_cnt;
    w_rx_bit_nx   = r_rx_bit;
    w_rx_shift_nx = r_rx_shift;
    w_rx_push     = 1'b0;
    w_rx_ferr_set = 1'b0;
    unique case (r_rx_state)
      RX_IDLE: begin
        if (!r_rx_s2) begin
          w_rx_state_nx = RX_START;
          w_rx_cnt_nx   = '0;
        end
      end
      RX_START: begin
        if (r_rx_cnt == C_HALF) begin
          w_rx_cnt_nx   = '0;
          w_rx_bit_nx   = '0;
          w_rx_state_nx = r_rx_s2 ? RX_IDLE : RX_DATA;
        end else begin
          w_rx_cnt_nx = r_rx_cnt + C_ONE;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == C_LAST) begin
          w_rx_cnt_nx   = '0;
          w_rx_shift_nx = {r_rx_s2, r_rx_shift[7:1]};
          w_rx_bit_nx   = r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) begin
            w_rx_state_nx = RX_STOP;
          end
        end else begin
          w_rx_cnt_nx = r_rx_cnt + C_ONE;
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == C_LAST) begin
          w_rx_cnt_nx   = '0;
          w_rx_state_nx = RX_IDLE;
          w_rx_push     = r_rx_s2;
          w_rx_ferr_set = !r_rx_s2;
        end else begin
          w_rx_cnt_nx = r_rx_cnt + C_ONE;
        end
      end
      default: w_rx_state_nx = RX_IDLE;
    endcase
  end

  // A byte is dropped only if the FIFO stays full this cycle
  assign w_rx_ovr_set = w_rx_push && w_rx_full && !w_rx_pop_ok;
  assign w_tx_ovf_set = tx_wren_in && w_tx_full && !w_tx_pop_ok;

  // TX state, shift register and registered line output
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nx;
      r_tx_cnt   <= w_tx_cnt_nx;
      r_tx_bit   <= w_tx_bit_nx;
      r_tx_shift <= w_tx_shift_nx;
      r_txd      <= w_txd_nx;
    end
  end

  // TX next state: stop bit chains straight into the next start bit
  always_comb begin
    w_tx_state_nx = r_tx_state;
    w_tx_cnt_nx   = r_tx_cnt;
    w_tx_bit_nx   = r_tx_bit;
    w_tx_shift_nx = r_tx_shift;
    w_tx_pop      = 1'b0;
    unique case (r_tx_state)
      TX_IDLE: begin
        if (!w_tx_empty) begin
          w_tx_pop      = 1'b1;
          w_tx_shift_nx = w_tx_head;
          w_tx_cnt_nx   = '0;
          w_tx_state_nx = TX_START;
        end
      end
      TX_START: begin
        if (r_tx_cnt == C_LAST) begin
          w_tx_cnt_nx   = '0;
          w_tx_bit_nx   = '0;
          w_tx_state_nx = TX_DATA;
        end else begin
          w_tx_cnt_nx = r_tx_cnt + C_ONE;
        end
      end
      TX_DATA: begin
        if (r_tx_cnt == C_LAST) begin
          w_tx_cnt_nx   = '0;
          w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
          w_tx_bit_nx   = r_tx_bit + 3'd1;
          if (r_tx_bit == 3'd7) begin
            w_tx_state_nx = TX_STOP;
          end
        end else begin
          w_tx_cnt_nx = r_tx_cnt + C_ONE;
        end
      end
      TX_STOP: begin
        if (r_tx_cnt == C_LAST) begin
          w_tx_cnt_nx = '0;
          if (!w_tx_empty) begin
            w_tx_pop      = 1'b1;
            w_tx_shift_nx = w_tx_head;
            w_tx_state_nx = TX_START;
          end else begin
            w_tx_state_nx = TX_IDLE;
          end
        end else begin
          w_tx_cnt_nx = r_tx_cnt + C_ONE;
        end
      end
      default: w_tx_state_nx = TX_IDLE;
    endcase
  end

  // Line level for the upcoming state, registered for a clean output
  always_comb begin
    w_txd_nx = 1'b1;
    unique case (w_tx_state_nx)
      TX_START: w_txd_nx = 1'b0;
      TX_DATA:  w_txd_nx = w_tx_shift_nx[0];
      default:  w_txd_nx = 1'b1;
    endcase
  end

  // Sticky error flags; a new event beats a clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rx_overrun   <= 1'b0;
      r_rx_frame_err <= 1'b0;
      r_tx_overflow  <= 1'b0;
    end else begin
      if (w_rx_ovr_set) begin
        r_rx_overrun <= 1'b1;
      end else if (err_clear_in) begin
        r_rx_overrun <= 1'b0;
      end
      if (w_rx_ferr_set) begin
        r_rx_frame_err <= 1'b1;
      end else if (err_clear_in) begin
        r_rx_frame_err <= 1'b0;
      end
      if (w_tx_ovf_set) begin
        r_tx_overflow <= 1'b1;
      end else if (err_clear_in) begin
        r_tx_overflow <= 1'b0;
      end
    end
  end

  assign uart_txd         = r_txd;
  assign rx_valid_out     = !w_rx_empty;
  assign tx_ready_out     = !w_tx_full;
  assign rx_overrun_out   = r_rx_overrun;
  assign rx_frame_err_out = r_rx_frame_err;
  assign tx_overflow_out  = r_tx_overflow;

endmodule

// File: tb/tb_uart_serial_bridge.sv
// tb_uart_serial_bridge: directed bench for the UART bridge.
// Vector table for RX frames plus hand sequences for TX and corners.

module tb_uart_serial_bridge;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       uart_txd;
  logic [7:0] rx_data_out;
  logic       rx_valid_out;
  logic       rx_rden_in = 1'b0;
  logic       tx_ready_out;
  logic [7:0] tx_data_in = 8'h00;
  logic       tx_wren_in = 1'b0;
  logic       err_clear_in = 1'b0;
  logic       rx_overrun_out;
  logic       rx_frame_err_out;
  logic       tx_overflow_out;

  int checks   = 0;
  int failures = 0;

  uart_serial_bridge #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .FIFO_AW      (AW)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .uart_rxd         (uart_rxd),
    .uart_txd         (uart_txd),
    .rx_data_out      (rx_data_out),
    .rx_valid_out     (rx_valid_out),
    .rx_rden_in       (rx_rden_in),
    .tx_ready_out     (tx_ready_out),
    .tx_data_in       (tx_data_in),
    .tx_wren_in       (tx_wren_in),
    .err_clear_in     (err_clear_in),
    .rx_overrun_out   (rx_overrun_out),
    .rx_frame_err_out (rx_frame_err_out),
    .tx_overflow_out  (tx_overflow_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       exp_valid;
    logic       exp_ferr;
  } rxv_t;

  rxv_t rxv [4];

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    uart_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      tick(CPB);
    end
    uart_rxd = stop;
    tick(CPB);
    uart_rxd = 1'b1;
    tick(12);
  endtask

  task automatic pop_rx();
    rx_rden_in = 1'b1;
    tick(1);
    rx_rden_in = 1'b0;
  endtask

  task automatic clear_err();
    err_clear_in = 1'b1;
    tick(1);
    err_clear_in = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [19:0] exp_bits;
    logic [7:0]  b0;
    logic [7:0]  b1;
    int          w;
    int          lows;

    rxv[0] = '{d: 8'hA5, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
    rxv[1] = '{d: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
    rxv[2] = '{d: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
    rxv[3] = '{d: 8'h5A, stop: 1'b0, exp_valid: 1'b0, exp_ferr: 1'b1};

    // reset
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    tick(1);
    chk("rst_txd", uart_txd, 1);
    chk("rst_ready", tx_ready_out, 1);
    chk("rst_valid", rx_valid_out, 0);
    chk("rst_data", rx_data_out, 8'h00);
    chk("rst_ovr", rx_overrun_out, 0);
    chk("rst_ferr", rx_frame_err_out, 0);
    chk("rst_ovf", tx_overflow_out, 0);

    // RX vector table
    for (int v = 0; v < 4; v++) begin
      send_frame(rxv[v].d, rxv[v].stop);
      chk($sformatf("rx%0d_valid", v), rx_valid_out, rxv[v].exp_valid);
      chk($sformatf("rx%0d_ferr", v), rx_frame_err_out, rxv[v].exp_ferr);
      if (rxv[v].exp_valid) begin
        chk($sformatf("rx%0d_data", v), rx_data_out, rxv[v].d);
        pop_rx();
        chk($sformatf("rx%0d_popped", v), rx_valid_out, 0);
      end
    end
    clear_err();
    chk("ferr_cleared", rx_frame_err_out, 0);

    // RX overrun: five frames into a four-entry FIFO
    for (int i = 0; i < 5; i++) begin
      send_frame(8'((i + 1) * 17), 1'b1);
      if (i == 3) chk("ovr_before_5th", rx_overrun_out, 0);
    end
    chk("ovr_set", rx_overrun_out, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovr_data%0d", i), rx_data_out, 8'((i + 1) * 17));
      pop_rx();
    end
    chk("ovr_drained", rx_valid_out, 0);
    clear_err();
    chk("ovr_cleared", rx_overrun_out, 0);

    // short glitch is rejected, then a normal frame still works
    uart_rxd = 1'b0;
    tick(2);
    uart_rxd = 1'b1;
    tick(20);
    chk("glitch_valid", rx_valid_out, 0);
    chk("glitch_ferr", rx_frame_err_out, 0);
    send_frame(8'hC3, 1'b1);
    chk("post_glitch_valid", rx_valid_out, 1);
    chk("post_glitch_data", rx_data_out, 8'hC3);
    pop_rx();

    // TX back-to-back 0x3C, 0x81
    b0 = 8'h3C;
    b1 = 8'h81;
    exp_bits[0]  = 1'b0;
    exp_bits[9]  = 1'b1;
    exp_bits[10] = 1'b0;
    exp_bits[19] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_bits[1 + i]  = b0[i];
      exp_bits[11 + i] = b1[i];
    end
    tx_data_in = b0;
    tx_wren_in = 1'b1;
    tick(1);
    tx_data_in = b1;
    tick(1);
    tx_wren_in = 1'b0;
    w = 0;
    while (uart_txd && w < 20) begin
      tick(1);
      w++;
    end
    chk("tx_start_seen", uart_txd, 0);
    tick(CPB / 2);
    for (int b = 0; b < 20; b++) begin
      chk($sformatf("tx_bit%0d", b), uart_txd, exp_bits[b]);
      tick(CPB);
    end
    chk("tx_idle_after", uart_txd, 1);
    chk("tx_ready_after", tx_ready_out, 1);

    // TX overflow while busy
    tx_data_in = 8'h10;
    tx_wren_in = 1'b1;
    tick(1);
    tx_wren_in = 1'b0;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      tx_data_in = 8'(8'h20 + i);
      tx_wren_in = 1'b1;
      tick(1);
      if (i == 3) begin
        chk("tx_full_ready", tx_ready_out, 0);
        chk("tx_ovf_not_yet", tx_overflow_out, 0);
      end
    end
    tx_wren_in = 1'b0;
    chk("tx_ovf_set", tx_overflow_out, 1);
    chk("tx_still_full", tx_ready_out, 0);
    clear_err();
    chk("tx_ovf_cleared", tx_overflow_out, 0);

    // reset mid TX frame
    tick(4);
    chk("tx_busy_low", uart_txd, 0);
    reset = 1'b0;
    #1;
    chk("txd_async_reset", uart_txd, 1);
    chk("tx_fifo_empty_rst", tx_ready_out, 1);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (!uart_txd) lows++;
    end
    chk("tx_quiet_after_rst", 8'(lows), 8'd0);
    chk("rx_empty_after_rst", rx_valid_out, 0);
    chk("tx_ready_after_rst", tx_ready_out, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_serial_bridge.md
Name: uart_serial_bridge

Overview:
- Connects the processor's byte-wide serial port to a physical 8N1 UART line pair.
- Receives UART frames on uart_rxd into an RX FIFO. Presents the head byte to the processor's serial_in/serial_valid_in inputs and pops it on serial_rden_out.
- Accepts bytes from the processor's serial_out/serial_wren_out into a TX FIFO, gated by serial_ready_in, and shifts them out on uart_txd.
- Sits at the top level beside the processor and drives the memory stage's serial interface.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200). Minimum 4.
- FIFO_DEPTH, 16, entries per FIFO. Power of two, minimum 2.
- FIFO_AW, 4, log2(FIFO_DEPTH).

Ports:
- clock  in  1  system clock; all state on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- uart_rxd  in  1  asynchronous serial line in; idles high.
- uart_txd  out  1  serial line out; idles high.
- rx_data_out  out  8  head byte of the RX FIFO; drives processor serial_in.
- rx_valid_out  out  1  RX FIFO non-empty; drives serial_valid_in.
- rx_rden_in  in  1  pop RX FIFO; from serial_rden_out.
- tx_ready_out  out  1  TX FIFO not full; drives serial_ready_in.
- tx_data_in  in  8  byte to send; from serial_out.
- tx_wren_in  in  1  push TX FIFO; from serial_wren_out.
- err_clear_in  in  1  clears the sticky error flags.
- rx_overrun_out  out  1  sticky: a received byte was dropped because the RX FIFO was full.
- rx_frame_err_out  out  1  sticky: a stop bit was sampled low.
- tx_overflow_out  out  1  sticky: a write was attempted with the TX FIFO full.

Behaviour:
- Reset values: uart_txd=1, rx_data_out=0, rx_valid_out=0, tx_ready_out=1, all error flags 0. Both FIFOs are empty, both FSMs are IDLE, and the RX synchronizer flops are preset to 1.
- Reset asserted mid-frame aborts the frame immediately. A partially received byte is discarded, a partially sent byte is lost, and uart_txd returns to 1 asynchronously.
- RX synchronizer: two flops on uart_rxd. The FSM uses only the synchronized value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronized low, with the counter cleared.
  - START: after CLKS_PER_BIT/2 cycles, resample. If still low go to DATA; if high, treat as a glitch and return to IDLE.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - STOP: sample once after CLKS_PER_BIT cycles.
    - Stop bit high: push the byte. If the FIFO is full, drop the byte and set rx_overrun_out.
    - Stop bit low: discard the byte and set rx_frame_err_out.
    - Either way, return to IDLE.
- FIFOs: synchronous, registered pointers of FIFO_AW+1 bits. The wrap bit distinguishes full from empty, and pointers wrap modulo 2*FIFO_DEPTH.
  - rx_data_out is combinational from the head entry, so the byte is valid in the same cycle as rx_valid_out.
  - Push lands the cycle after the strobe; rx_valid_out rises one cycle after the stop-bit sample.
  - Simultaneous push and pop on a non-empty FIFO: both happen and the count is unchanged.
  - Simultaneous push and pop on an empty FIFO: the pop is ignored and the push happens.
  - Simultaneous push and pop on a full FIFO: both happen, no drop and no flag.
  - rx_rden_in while empty: ignored. tx_wren_in while full: ignored and sets tx_overflow_out.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the TX FIFO is non-empty, pop one byte into the shift register and go to START.
  - START drives 0 for CLKS_PER_BIT cycles.
  - DATA drives 8 bits LSB first, each for CLKS_PER_BIT cycles.
  - STOP drives 1 for CLKS_PER_BIT cycles, then returns to IDLE.
  - Back-to-back bytes have no extra idle gap: the next start bit follows the stop bit immediately.
  - uart_txd is driven from a register (glitch-free).
- Error flags: sticky until err_clear_in. If err_clear_in and a set event occur in the same cycle, the set wins.
- Throughput: one byte per 10*CLKS_PER_BIT cycles in each direction. The two directions run independently (full duplex).

Test Plan (CLKS_PER_BIT=8, FIFO_DEPTH=4):
- Reset hold low for 3 cycles, then release -> uart_txd=1, tx_ready_out=1, rx_valid_out=0, all flags 0.
- Drive frame 0xA5 on uart_rxd (bits 1,0,1,0,0,1,0,1 LSB first) -> rx_valid_out=1 and rx_data_out=0xA5 within 2 cycles after the stop-bit centre. Pulse rx_rden_in -> rx_valid_out=0 the next cycle.
- Write 0x3C then 0x81 on consecutive cycles -> uart_txd shows start, 00111100 LSB-first, stop, then immediately start, 10000001 LSB-first, stop. Each bit is 8 cycles; total 160 cycles.
- Write 5 bytes back-to-back while TX is busy -> tx_ready_out=0 once the FIFO holds 4 entries and tx_overflow_out=1. err_clear_in -> flag returns to 0.
- Receive 5 frames without popping -> 4 bytes are retained in order and rx_overrun_out=1. Send a frame with stop bit 0 -> rx_frame_err_out=1 and the byte is not pushed.
- A 2-cycle low glitch on uart_rxd -> no byte and no flag, RX returns to IDLE. Assert reset mid TX frame -> uart_txd=1 immediately and the FIFOs are empty afterwards.
